lsu_dmem_if: RTL
================

LSU_DMEM_IF -- requirements
Module: lsu_dmem_if

Interface
- REQ-001 SHALL have parameter AWIDTH, default 32: byte-address width.
- REQ-002 SHALL have parameter DWIDTH, default 32: data width; only 32 is supported.
- REQ-003 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
- REQ-005 SHALL have port req_valid, input, 1: the core presents a load/store request.
- REQ-006 SHALL have port req_ready, output, 1: the block accepts a request this cycle.
- REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
- REQ-008 SHALL have port req_funct3, input, 3: RV32I width code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- REQ-009 SHALL have port req_addr, input, AWIDTH: byte address (ALU result).
- REQ-010 SHALL have port req_wdata, input, DWIDTH: store data (rs2).
- REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
- REQ-012 SHALL have port resp_rdata, output, DWIDTH: extended load data; 0 for stores and errors.
- REQ-013 SHALL have port resp_err, output, 1: misaligned or illegal access; qualified by resp_valid.
- REQ-014 SHALL have port mem_en, output, 1: data-RAM access strobe.
- REQ-015 SHALL have port mem_we, output, 1: data-RAM write enable; qualified by mem_en.
- REQ-016 SHALL have port mem_be, output, 4: byte-lane enables; bit i drives bits [8i+7:8i].
- REQ-017 SHALL have port mem_addr, output, AWIDTH-2: word index, req_addr[AWIDTH-1:2].
- REQ-018 SHALL have port mem_wdata, output, DWIDTH: lane-replicated store data.
- REQ-019 SHALL have port mem_rdata, input, DWIDTH: RAM read word, valid the cycle after a read strobe.

Function
- REQ-020 SHALL use a 4-state FSM (IDLE, ACCESS, RDWAIT, RESP); req_ready SHALL be 1 only in IDLE.
- REQ-021 In IDLE, on req_valid, SHALL register req_we, req_funct3, req_addr and req_wdata.
- REQ-022 From IDLE with an accepted request SHALL go to RESP with err=1 on error and no memory strobe; otherwise SHALL go to ACCESS.
- REQ-023 Error SHALL be defined as: halfword with addr[0]=1; word with addr[1:0]!=00; funct3 011/110/111; store with funct3[2]=1.
- REQ-024 In ACCESS, mem_en SHALL be 1 for exactly one cycle with mem_we = the registered req_we; a store SHALL go to RESP and a load to RDWAIT.
- REQ-025 In RDWAIT, SHALL sample mem_rdata, select the lane by addr[1:0] (halfword by addr[1]), sign-extend for LB/LH or zero-extend for LBU/LHU, then go to RESP.
- REQ-026 In RESP, resp_valid SHALL be 1 for one cycle, with no backpressure, then the FSM SHALL go to IDLE.
- REQ-027 Latency SHALL be: store accepted at cycle N -> RAM write at N+1 -> resp_valid at N+2; load -> read at N+1 -> resp_valid at N+3; error -> resp_valid at N+1.
- REQ-028 For stores, mem_be SHALL be: SB 0001<<addr[1:0]; SH 0011 (addr[1]=0) or 1100 (addr[1]=1); SW 1111.
- REQ-029 For stores, mem_wdata SHALL be: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- REQ-030 For loads, mem_be SHALL be 1111.
- REQ-031 When mem_en=0, mem_we, mem_be and mem_wdata SHALL be 0.
- REQ-032 resp_rdata and resp_err SHALL hold their values only while resp_valid=1 and SHALL be 0 otherwise.
- REQ-033 req_valid outside IDLE SHALL be ignored; the core holds it until req_ready.

Reset
- REQ-034 rst=0 SHALL immediately force IDLE and set req_ready=1 and resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata to 0.
- REQ-035 Reset in ACCESS/RDWAIT/RESP SHALL abort the operation: no further mem_en and no resp_valid for it.
- REQ-036 The first request SHALL be accepted on the first rising edge after rst deasserts.

Verification
- REQ-037 SW addr 0x0000_0008, wdata 0xDEAD_BEEF -> at N+1: mem_en=1, we=1, mem_addr=2, be=1111, wdata=0xDEADBEEF; resp_valid at N+2 with err=0.
- REQ-038 SB addr 0x0000_0006, wdata 0x0000_00A5 -> mem_be=0100, mem_wdata=0xA5A5_A5A5.
- REQ-039 mem word 0x8070_F0FF: LB addr 0x1 -> 0xFFFF_FFF0; LBU addr 0x1 -> 0x0000_00F0; LH addr 0x2 -> 0xFFFF_8070; LHU addr 0x2 -> 0x0000_8070; each resp_valid at N+3.
- REQ-040 LW addr 0x0000_0006 -> no mem_en; resp_valid at N+1 with err=1 and rdata=0; funct3 011 -> same.
- REQ-041 Back-to-back: req_valid held high with two loads -> second accepted only after the first resp, req_ready low for 3 cycles.
- REQ-042 rst pulsed low during RDWAIT -> outputs 0 asynchronously, no resp_valid; a following SW completes normally.

Source files
------------

// File: rtl/lsu_dmem_if.sv
// RV32I load/store unit front end to a single-port data RAM.
// It registers one request at a time, aligns the store lanes and extends the load data.
module lsu_dmem_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [AWIDTH-3:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              op_we;
  logic [2:0]        op_funct3;
  logic [AWIDTH-1:0] op_addr;
  logic [DWIDTH-1:0] op_wdata;
  logic              resp_valid_next;
  logic              resp_err_next;
  logic [DWIDTH-1:0] resp_rdata_next;

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = a[0];
      3'b010:  access_err = (a != 2'b00);
      3'b100:  access_err = we;
      3'b101:  access_err = we | a[0];
      default: access_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = rd;
    endcase
  endfunction

  assign req_ready = (state == IDLE);

  // RAM strobes come straight from the state register, so reset clears them immediately.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = op_we;
      mem_be    = op_we ? store_be(op_funct3, op_addr[1:0]) : 4'b1111;
      mem_addr  = op_addr[AWIDTH-1:2];
      mem_wdata = op_we ? store_data(op_funct3, op_wdata) : '0;
    end else begin
      mem_en = 1'b0;
    end
  end

  always_comb begin
    next_state      = state;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (access_err(req_we, req_funct3, req_addr[1:0])) begin
            next_state      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            next_state = ACCESS;
          end
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        if (op_we) begin
          next_state      = RESP;
          resp_valid_next = 1'b1;
        end else begin
          next_state = RDWAIT;
        end
      end
      RDWAIT: begin
        next_state      = RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_ext(op_funct3, op_addr[1:0], mem_rdata);
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request capture; held for the whole operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_we     <= 1'b0;
      op_funct3 <= 3'b000;
      op_addr   <= '0;
      op_wdata  <= '0;
    end else if (state == IDLE && req_valid) begin
      op_we     <= req_we;
      op_funct3 <= req_funct3;
      op_addr   <= req_addr;
      op_wdata  <= req_wdata;
    end else begin
      op_we <= op_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
    end
  end

endmodule
